// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the FIC fabric bridges:
//   - HTRANS / HRESP / HSIZE encodings
//   - responder (slave) FSM state encoding
//   - byte_lane(): pick one byte out of a 32-bit bus word by address[1:0].
//     The same helper is used by the initiator side, so lane mapping is defined
//     in exactly one place.
// ---------------------------------------------------------------------------
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Only byte transfers reach the 8-bit backend
    localparam logic [2:0] HSIZE_BYTE = 3'b000;

    // Responder FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,   // ready, accepting new address phases
        ST_WDATA = 3'd1,   // write data phase, HWDATA being captured
        ST_ACK   = 3'd2,   // backend request outstanding
        ST_ERR1  = 3'd3,   // first ERROR cycle (HREADYOUT low)
        ST_ERR2  = 3'd4    // second ERROR cycle (HREADYOUT high)
    } slv_state_t;

    // Little-endian byte lane select: lane 0 is bits [7:0]
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] sel;
        case (lane)
            2'b00:   sel = word[7:0];
            2'b01:   sel = word[15:8];
            2'b10:   sel = word[23:16];
            2'b11:   sel = word[31:24];
            default: sel = word[7:0];
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ahb_slave_bridge.sv
// ---------------------------------------------------------------------------
// ahb_slave_bridge
// AHB-Lite responder that forwards single byte transfers to an 8-bit req/ack
// backend (i8080-side memory/IO space).
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,  AHB-Lite address phase
//   HWRITE, HSIZE, HREADY
//   HWDATA                AHB-Lite write data (data phase)
//   HREADYOUT, HRESP,     AHB-Lite responder outputs (all registered)
//   HRDATA
//   mem_req, mem_we,      backend request; level held until mem_ack or
//   mem_addr, mem_wdata   timeout, address/direction stable while held
//   mem_rdata, mem_ack    backend completion (single-cycle pulse + read byte)
//
// Wait states: read = 1 + ack latency, write = 2 + ack latency. Transfers
// with HSIZE other than byte, and backend timeouts, get the two-cycle ERROR
// response. The completion cycle (state IDLE, HREADYOUT high) also accepts,
// so pipelined transfers run back to back; the ERR2 cycle does not accept.
// ---------------------------------------------------------------------------
module ahb_slave_bridge
    import ahb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    // Timeout limit widened by one bit so the incremented count never wraps
    // before the compare.
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

    slv_state_t  state_r;
    logic [1:0]  lane_r;      // HADDR[1:0] of the transfer in flight
    logic        write_r;     // HWRITE of the transfer in flight
    logic [7:0]  cnt_r;       // cycles spent waiting for mem_ack

    logic        accept_s;
    logic        size_ok_s;
    logic [8:0]  cnt_inc_s;
    logic        ack_timeout_s;
    logic        unused_s;

    // Address-phase decode and timeout detection
    always_comb begin
        accept_s      = (state_r == ST_IDLE) && HSEL && HREADY && HTRANS[1];
        size_ok_s     = (HSIZE == HSIZE_BYTE);
        cnt_inc_s     = {1'b0, cnt_r} + 9'd1;
        ack_timeout_s = (cnt_inc_s >= TIMEOUT_LIM);
    end

    // Upper address bits and HTRANS[0] do not affect this responder
    assign unused_s = ^{HADDR[31:ADDR_W], HTRANS[0]};

    // Responder FSM: address capture, wait states, backend handshake, ERROR
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            lane_r    <= 2'b00;
            write_r   <= 1'b0;
            cnt_r     <= 8'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        lane_r    <= HADDR[1:0];
                        mem_addr  <= HADDR[ADDR_W-1:0];
                        write_r   <= HWRITE;
                        cnt_r     <= 8'd0;
                        HREADYOUT <= 1'b0;
                        if (!size_ok_s) begin
                            // Unsupported size never reaches the backend
                            HRESP   <= HRESP_ERROR;
                            state_r <= ST_ERR1;
                        end else if (HWRITE) begin
                            // HWDATA is only valid in the next cycle
                            state_r <= ST_WDATA;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            state_r <= ST_ACK;
                        end
                    end else begin
                        // IDLE/BUSY, deselected or stalled bus: zero-wait OKAY
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end

                ST_WDATA: begin
                    mem_wdata <= byte_lane(HWDATA, lane_r);
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    state_r   <= ST_ACK;
                end

                ST_ACK: begin
                    cnt_r <= cnt_inc_s[7:0];
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        HREADYOUT <= 1'b1;
                        state_r   <= ST_IDLE;
                        if (!write_r) begin
                            // Replicate so any byte lane the initiator reads is valid
                            HRDATA <= {4{mem_rdata}};
                        end else begin
                            HRDATA <= HRDATA;
                        end
                    end else if (ack_timeout_s) begin
                        // Abandon the backend request; it must tolerate the drop
                        mem_req <= 1'b0;
                        HRESP   <= HRESP_ERROR;
                        state_r <= ST_ERR1;
                    end else begin
                        state_r <= ST_ACK;
                    end
                end

                ST_ERR1: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                    state_r   <= ST_ERR2;
                end

                ST_ERR2: begin
                    // Initiator cancels here, so nothing is accepted this cycle
                    HRESP   <= HRESP_OKAY;
                    state_r <= ST_IDLE;
                end

                default: begin
                    state_r   <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_bridge
// Randomised bench for ahb_slave_bridge. A behavioural backend answers
// mem_req after a chosen number of cycles; each transfer's expected wait
// states, response, backend request contents and HRDATA are computed from
// the transfer's properties with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ahb_slave_bridge;
    import ahb_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              resetn;
    logic              HSEL;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    ahb_slave_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Backend model state
    int                ack_delay = 0;   // ack in request cycle ack_delay+1
    logic [7:0]        be_rdata  = 8'h00;
    int                req_cycles = 0;
    int                req_count  = 0;
    int                req_len_last = 0;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [7:0]        cap_wdata;
    bit                stable_err = 1'b0;

    // Reference state
    logic [31:0] hrdata_m = 32'h0;

    // Next transfer for pipelined (chained) issue
    logic [31:0] nxt_a;
    logic        nxt_w;
    logic [2:0]  nxt_sz;
    logic [31:0] nxt_wd;
    int          nxt_dly;
    logic [7:0]  nxt_rd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Backend responder: sampled and driven on the falling edge
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (resetn === 1'b1 && mem_req === 1'b1) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    req_count++;
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end else if (mem_addr !== cap_addr || mem_we !== cap_we) begin
                    stable_err = 1'b1;
                end
                if (req_cycles == ack_delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = be_rdata;
                end else begin
                    mem_rdata = 8'($urandom);
                end
            end else begin
                if (req_cycles != 0) req_len_last = req_cycles;
                req_cycles = 0;
            end
        end
    end

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HREADY = 1'b1;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input int dly, input logic [7:0] rd);
        HSEL      = 1'b1;
        HADDR     = a;
        HTRANS    = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        HWRITE    = w;
        HSIZE     = sz;
        HREADY    = 1'b1;
        ack_delay = dly;
        be_rdata  = rd;
    endtask

    // One transfer. presented: address already driven in the previous
    // completion cycle. chain: drive nxt_* in this transfer's completion cycle.
    task automatic run_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                            input logic [31:0] wd, input int dly, input logic [7:0] rd,
                            input bit presented, input bit chain);
        bit  size_err;
        bit  tmo;
        bit  err;
        int  exp_waits;
        int  waits;
        bit  done;
        logic last_resp;
        int  req_before;
        logic [7:0] exp_byte;

        size_err = (sz != HSIZE_BYTE);
        tmo      = !size_err && (dly >= TIMEOUT);
        err      = size_err || tmo;
        if (size_err)  exp_waits = 1;
        else if (tmo)  exp_waits = (w ? 1 : 0) + TIMEOUT + 1;
        else           exp_waits = (w ? 1 : 0) + dly + 1;
        exp_byte   = 8'(wd >> (8 * int'(a[1:0])));
        req_before = req_count;

        if (!presented) begin
            @(negedge clk);
            drive_addr(a, w, sz, dly, rd);
        end
        @(posedge clk);
        #1;
        idle_bus();
        HWDATA = wd;

        waits = 0; done = 1'b0; last_resp = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (HREADYOUT === 1'b1) done = 1'b1;
            else begin
                waits++;
                last_resp = HRESP;
            end
        end
        check_eq("completed", 32'(done), 32'd1);
        check_eq("wait_states", waits, exp_waits);
        check_eq("hresp_final", 32'(HRESP), 32'(err));
        check_eq("hresp_last_wait", 32'(last_resp), 32'(err));
        if (!size_err) begin
            check_eq("req_count", req_count, req_before + 1);
            check_eq("mem_addr", 32'(cap_addr), 32'(a[ADDR_W-1:0]));
            check_eq("mem_we", 32'(cap_we), 32'(w));
            if (w) check_eq("mem_wdata", 32'(cap_wdata), 32'(exp_byte));
            check_eq("req_stable", 32'(stable_err), 32'd0);
            if (tmo) check_eq("timeout_req_len", req_len_last, TIMEOUT);
        end else begin
            check_eq("no_req_on_size_err", req_count, req_before);
        end
        if (!w && !err) hrdata_m = {4{rd}};
        check_eq("hrdata", HRDATA, hrdata_m);

        if (chain) begin
            drive_addr(nxt_a, nxt_w, nxt_sz, nxt_dly, nxt_rd);
        end else begin
            if (err) begin
                // Transfer offered during ERR2 must be ignored
                drive_addr(32'($urandom), 1'b0, HSIZE_BYTE, 0, 8'h00);
                @(posedge clk);
                #1;
                idle_bus();
            end
            @(negedge clk);
            check_eq("post_readyout", 32'(HREADYOUT), 32'd1);
            check_eq("post_hresp", 32'(HRESP), 32'd0);
            check_eq("post_no_req", 32'(mem_req), 32'd0);
        end
    endtask

    // Non-accepted bus cycles must give zero-wait OKAY and no backend activity
    task automatic idle_probe();
        int kind;
        @(negedge clk);
        kind = $urandom_range(0, 3);
        HADDR  = 32'($urandom);
        HWRITE = 1'($urandom);
        HSIZE  = HSIZE_BYTE;
        case (kind)
            0: begin HSEL = 1'b0; HTRANS = HTRANS_NONSEQ; HREADY = 1'b1; end
            1: begin HSEL = 1'b1; HTRANS = HTRANS_IDLE;   HREADY = 1'b1; end
            2: begin HSEL = 1'b1; HTRANS = HTRANS_BUSY;   HREADY = 1'b1; end
            default: begin HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HREADY = 1'b0; end
        endcase
        @(posedge clk);
        #1;
        idle_bus();
        @(negedge clk);
        check_eq("idle_readyout", 32'(HREADYOUT), 32'd1);
        check_eq("idle_hresp", 32'(HRESP), 32'd0);
        check_eq("idle_no_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ca;
        logic        cw;
        logic [2:0]  cs;
        logic [31:0] cwd;
        int          cd;
        logic [7:0]  cr;
        bit          pres;
        bit          ch;

        resetn = 1'b0;
        idle_bus();
        HADDR = 32'h0; HWRITE = 1'b0; HSIZE = HSIZE_BYTE; HWDATA = 32'h0;
        #12;
        check_eq("rst_readyout", 32'(HREADYOUT), 32'd1);
        check_eq("rst_hresp", 32'(HRESP), 32'd0);
        check_eq("rst_hrdata", HRDATA, 32'h0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_bus", {15'h0, mem_we, mem_addr}, 32'h0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed cases
        run_xfer(32'h0000_1235, 1'b0, HSIZE_BYTE, 32'h0, 3, 8'hA5, 1'b0, 1'b0);
        check_eq("read_a5_hrdata", HRDATA, 32'hA5A5_A5A5);
        run_xfer(32'h0000_0102, 1'b1, HSIZE_BYTE, 32'h00C3_0000, 0, 8'h00, 1'b0, 1'b0);
        run_xfer(32'h0000_2000, 1'b0, 3'b001, 32'h0, 0, 8'h11, 1'b0, 1'b0);
        run_xfer(32'h0000_3333, 1'b0, HSIZE_BYTE, 32'h0, 1000, 8'h00, 1'b0, 1'b0);
        run_xfer(32'h0000_0003, 1'b1, HSIZE_BYTE, 32'h9E00_0000, 1000, 8'h00, 1'b0, 1'b0);

        // Back-to-back write 0x10 then read 0x11
        nxt_a = 32'h0000_0011; nxt_w = 1'b0; nxt_sz = HSIZE_BYTE;
        nxt_wd = 32'h0; nxt_dly = 1; nxt_rd = 8'h5A;
        run_xfer(32'h0000_0010, 1'b1, HSIZE_BYTE, 32'h0000_0077, 0, 8'h00, 1'b0, 1'b1);
        run_xfer(nxt_a, nxt_w, nxt_sz, nxt_wd, nxt_dly, nxt_rd, 1'b1, 1'b0);
        check_eq("b2b_read_hrdata", HRDATA, 32'h5A5A_5A5A);

        // Randomised transfers, some pipelined back to back
        ca = 32'($urandom); cw = 1'($urandom); cwd = 32'($urandom);
        cs = HSIZE_BYTE; cd = $urandom_range(0, 5); cr = 8'($urandom);
        pres = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ch = ($urandom_range(0, 2) == 0) && (i < 39) && (cs == HSIZE_BYTE);
            nxt_a  = 32'($urandom);
            nxt_w  = 1'($urandom);
            nxt_wd = 32'($urandom);
            nxt_sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : HSIZE_BYTE;
            nxt_dly = $urandom_range(0, 5);
            nxt_rd = 8'($urandom);
            run_xfer(ca, cw, cs, cwd, cd, cr, pres, ch);
            if (!ch && $urandom_range(0, 2) == 0) idle_probe();
            ca = nxt_a; cw = nxt_w; cs = nxt_sz; cwd = nxt_wd; cd = nxt_dly; cr = nxt_rd;
            pres = ch;
        end

        // Asynchronous reset while a backend request is pending
        @(negedge clk);
        drive_addr(32'h0000_4321, 1'b0, HSIZE_BYTE, 1000, 8'h00);
        @(posedge clk);
        #1;
        idle_bus();
        repeat (6) @(negedge clk);
        check_eq("pre_rst_req", 32'(mem_req), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_readyout", 32'(HREADYOUT), 32'd1);
        check_eq("arst_hresp", 32'(HRESP), 32'd0);
        check_eq("arst_hrdata", HRDATA, 32'h0);
        check_eq("arst_mem_req", 32'(mem_req), 32'd0);
        check_eq("arst_mem_bus", {15'h0, mem_we, mem_addr}, 32'h0);
        check_eq("arst_mem_wdata", 32'(mem_wdata), 32'h0);
        hrdata_m = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        run_xfer(32'h0000_0ABC, 1'b0, HSIZE_BYTE, 32'h0, 2, 8'h3C, 1'b0, 1'b0);
        check_eq("post_rst_read", HRDATA, 32'h3C3C_3C3C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
